// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver with start detection, mid-bit sampling, stop check and one-entry output buffer
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 shift_en,
  output logic                 sample_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_d;
  logic s1, rx_s, rx_q, done, done_d, valid_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [IW-1:0] idx, idx_d;
  logic [DATA_BITS-1:0] sh, sh_d, sh_n, data_d;
  logic tick;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      rx_s     <= 1'b1;
      rx_q     <= 1'b1;
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      done     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      s1       <= rx;
      rx_s     <= s1;
      rx_q     <= rx_s;
      state    <= state_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      sh       <= sh_d;
      done     <= done_d;
      rx_valid <= valid_d;
      rx_data  <= data_d;
    end
  end
  always_comb begin
    sh_n = sh;
    sh_n[DATA_BITS-1] = rx_s;
    for (int i = 0; i < DATA_BITS - 1; i++) sh_n[i] = sh[i+1];
  end
  assign tick = cnt == LAST;
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + 1'b1;
    idx_d     = idx;
    sh_d      = sh;
    done_d    = 1'b0;
    shift_en  = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (rx_q && !rx_s) state_d = START;
      end
      START: if (cnt == HALF) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d    = '0;
        shift_en = 1'b1;
        sh_d     = sh_n;
        idx_d    = idx + 1'b1;
        if (idx == IDX_LAST) state_d = STOP;
      end
      default: if (tick) begin
        cnt_d     = '0;
        state_d   = IDLE;
        done_d    = rx_s;
        frame_err = !rx_s;
      end
    endcase
  end
  // a completed byte lands one cycle after the stop sample; it may replace a byte consumed that same cycle
  assign valid_d    = done ? 1'b1 : rx_valid & !rx_ready ? 1'b1 : 1'b0;
  assign data_d     = done && (!rx_valid || rx_ready) ? sh : rx_data;
  assign overrun    = done && rx_valid && !rx_ready;
  assign sample_bit = shift_en & rx_s;
  assign busy       = state != IDLE;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and random frames against a bit-list reference model
module tb_uart_rx_ctrl;
  localparam int C = 16;
  logic clk = 0, rst_n = 0, rx = 1, rx7 = 1, rx_ready = 0, rx_ready7 = 0;
  logic shift_en, sample_bit, rx_valid, frame_err, overrun, busy;
  logic [7:0] rx_data;
  logic shift_en7, sample_bit7, rx_valid7, frame_err7, overrun7, busy7;
  logic [6:0] rx_data7;
  int n_assert = 0, n_fail = 0;
  int nsh = 0, nfe = 0, nov = 0, nsh7 = 0, vdrop = 0;
  bit watch = 0;
  bit bits[$];
  uart_rx_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .shift_en(shift_en), .sample_bit(sample_bit),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .busy(busy));
  uart_rx_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .rx(rx7), .shift_en(shift_en7), .sample_bit(sample_bit7),
    .rx_data(rx_data7), .rx_valid(rx_valid7), .rx_ready(rx_ready7), .frame_err(frame_err7),
    .overrun(overrun7), .busy(busy7));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (shift_en) begin
      nsh++;
      bits.push_back(sample_bit);
    end
    if (frame_err) nfe++;
    if (overrun) nov++;
    if (shift_en7) nsh7++;
    if (watch && !rx_valid) vdrop++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  function automatic logic [31:0] packed_bits();
    logic [31:0] r = 0;
    foreach (bits[i]) r[i] = bits[i];
    return r;
  endfunction
  task automatic send(input logic [7:0] d, input bit on7, input logic stop, input bit pulse, input int rst_bit);
    int nb;
    logic v, bp;
    nb = on7 ? 7 : 8;
    bp = busy;
    for (int i = 0; i < nb + 2; i++) begin
      v = i == 0 ? 1'b0 : i == nb + 1 ? stop : d[i-1];
      for (int c = 0; c < C; c++) begin
        if (rst_bit >= 0 && i == rst_bit + 1 && c == C / 2) begin
          rst_n = 0;
          #1;
          chk("rst_busy", busy, 0);
          chk("rst_valid", rx_valid, 0);
          chk("rst_data", rx_data, 0);
          chk("rst_shift_en", shift_en, 0);
          chk("rst_sample_bit", sample_bit, 0);
          chk("rst_flags", {frame_err, overrun}, 0);
          return;
        end
        if (on7) rx7 = v;
        else rx = v;
        if (pulse) begin
          rx_ready = bp & ~busy;
          bp = busy;
        end
        step();
      end
    end
    if (pulse) rx_ready = 0;
  endtask
  task automatic wait_valid(input bit on7, input int lim);
    int k = 0;
    while (!(on7 ? rx_valid7 : rx_valid) && k < lim) begin
      step();
      k++;
    end
    chk("valid_timeout", on7 ? rx_valid7 : rx_valid, 1);
  endtask
  task automatic consume();
    rx_ready = 1;
    step();
    rx_ready = 0;
    chk("consume_clears", rx_valid, 0);
  endtask
  initial begin
    logic [7:0] d;
    int mm;
    idle(3);
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {shift_en, sample_bit, frame_err, overrun}, 0);
    rst_n = 1;
    idle(5);
    nsh = 0;
    bits.delete();
    send(8'hA5, 0, 1, 0, -1);
    idle(4);
    wait_valid(0, 50);
    chk("a5_nshift", nsh, 8);
    chk("a5_bits", packed_bits(), 32'hA5);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_errs", {nfe[0], nov[0]}, 0);
    consume();
    nsh = 0;
    rx = 0;
    idle(5);
    rx = 1;
    idle(3);
    chk("glitch_in_start", busy, 1);
    idle(30);
    chk("glitch_idle", busy, 0);
    chk("glitch_nshift", nsh, 0);
    chk("glitch_valid", rx_valid, 0);
    nfe = 0;
    send(8'h3C, 0, 0, 0, -1);
    idle(40);
    chk("ferr_pulses", nfe, 1);
    chk("ferr_valid", rx_valid, 0);
    chk("stuck_low_idle", busy, 0);
    rx = 1;
    idle(4);
    nsh = 0;
    bits.delete();
    send(8'h81, 0, 1, 0, -1);
    wait_valid(0, 50);
    chk("after_ferr_data", rx_data, 8'h81);
    chk("after_ferr_bits", packed_bits(), 32'h81);
    consume();
    nov = 0;
    send(8'h11, 0, 1, 0, -1);
    send(8'h22, 0, 1, 0, -1);
    idle(4);
    chk("ovr_pulses", nov, 1);
    chk("ovr_data_kept", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1);
    consume();
    nov = 0;
    send(8'h11, 0, 1, 0, -1);
    wait_valid(0, 50);
    vdrop = 0;
    watch = 1;
    send(8'h22, 0, 1, 1, -1);
    idle(2);
    watch = 0;
    chk("swap_data", rx_data, 8'h22);
    chk("swap_valid", rx_valid, 1);
    chk("swap_no_ovr", nov, 0);
    chk("swap_valid_held", vdrop, 0);
    send(8'hF0, 0, 1, 0, 4);
    rx = 1;
    idle(3);
    rst_n = 1;
    idle(5);
    chk("post_rst_valid", rx_valid, 0);
    nsh = 0;
    bits.delete();
    send(8'h5A, 0, 1, 0, -1);
    wait_valid(0, 50);
    chk("post_rst_data", rx_data, 8'h5A);
    chk("post_rst_nshift", nsh, 8);
    consume();
    nsh7 = 0;
    send(8'h55, 1, 1, 0, -1);
    wait_valid(1, 50);
    chk("w7_data", rx_data7, 7'h55);
    chk("w7_nshift", nsh7, 7);
    rx_ready7 = 1;
    step();
    rx_ready7 = 0;
    nsh7 = 0;
    send(8'h2A, 1, 1, 0, -1);
    wait_valid(1, 50);
    chk("w7_data2", rx_data7, 7'h2A);
    chk("w7_nshift2", nsh7, 7);
    repeat (20) begin
      d = 8'($urandom_range(0, 255));
      idle($urandom_range(0, 20));
      nsh = 0;
      bits.delete();
      send(d, 0, 1, 0, -1);
      wait_valid(0, 50);
      chk("rnd_data", rx_data, d);
      chk("rnd_nbits", bits.size(), 8);
      mm = 0;
      for (int i = 0; i < 8; i++)
        if (i < bits.size() && 32'(bits[i]) != ((32'(d) >> i) & 1)) mm++;
      chk("rnd_bit_order", mm, 0);
      consume();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
